verin_adc_spi_responder: RTL and testbench

VERIN_ADC_SPI_RESPONDER -- requirements
Module: verin_adc_spi_responder

---
 rtl/verin_adc_spi_responder_if.sv | 10 +
 rtl/verin_adc_spi_responder.sv | 123 ++++++++++++
 tb/tb_verin_adc_spi_responder.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/verin_adc_spi_responder_if.sv
// SPI link between the verin SPI master and the ADC responder.
// Signal names follow the responder's side of the link.
interface verin_adc_spi_responder_if;
    logic sck_i;
    logic cs_n_i;
    logic miso_o;

    modport master (output sck_i, output cs_n_i, input miso_o);
    modport slave  (input sck_i, input cs_n_i, output miso_o);
endinterface

// File: rtl/verin_adc_spi_responder.sv
// Emulates an ADC on the verin SPI bus: sends a null-prefixed, MSB-first conversion word
// on sck falling edges, with oversampled (synchronized) sck/cs_n.
module verin_adc_spi_responder #(
    parameter int DATA_W      = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    verin_adc_spi_responder_if.slave spi,
    input  logic [DATA_W-1:0]    data_i,
    output logic                 busy_o,
    output logic                 frame_done_o,
    output logic                 abort_o,
    output logic [7:0]           frame_cnt_o
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {IDLE, SAMPLE, NULLB, DATA, TRAIL} state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sck_sync, cs_sync;
    logic                   sck_d, cs_d;
    logic                   sck_fall, cs_fall, cs_rise;
    logic [DATA_W-1:0]      shreg, shreg_nxt;
    logic [CNT_W-1:0]       bit_cnt, bit_cnt_nxt;
    logic                   miso, miso_nxt;
    logic                   done_nxt, abort_nxt;
    logic [7:0]             cnt_nxt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sck_sync <= '0;
            cs_sync  <= '1;
            sck_d    <= 1'b0;
            cs_d     <= 1'b1;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], spi.sck_i};
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], spi.cs_n_i};
            sck_d    <= sck_sync[SYNC_STAGES-1];
            cs_d     <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign sck_fall = sck_d & ~sck_sync[SYNC_STAGES-1];
    assign cs_fall  = cs_d & ~cs_sync[SYNC_STAGES-1];
    assign cs_rise  = ~cs_d & cs_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            shreg        <= '0;
            bit_cnt      <= '0;
            miso         <= 1'b0;
            frame_done_o <= 1'b0;
            abort_o      <= 1'b0;
            frame_cnt_o  <= 8'd0;
        end else begin
            state        <= state_nxt;
            shreg        <= shreg_nxt;
            bit_cnt      <= bit_cnt_nxt;
            miso         <= miso_nxt;
            frame_done_o <= done_nxt;
            abort_o      <= abort_nxt;
            frame_cnt_o  <= cnt_nxt;
        end
    end

    // cs_n edges are checked before sck edges so a coincident sck edge is dropped.
    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        miso_nxt    = miso;
        done_nxt    = 1'b0;
        abort_nxt   = 1'b0;
        cnt_nxt     = frame_cnt_o;
        case (state)
            IDLE: begin
                miso_nxt = 1'b0;
                if (cs_fall) begin
                    shreg_nxt   = data_i;
                    bit_cnt_nxt = '0;
                    state_nxt   = SAMPLE;
                end
            end
            SAMPLE, NULLB, DATA: begin
                if (cs_rise) begin
                    abort_nxt = 1'b1;
                    miso_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else if (sck_fall) begin
                    if (state == SAMPLE) begin
                        miso_nxt  = 1'b0;
                        state_nxt = NULLB;
                    end else if (state == NULLB) begin
                        miso_nxt  = 1'b0;
                        state_nxt = DATA;
                    end else begin
                        miso_nxt    = shreg[DATA_W-1];
                        shreg_nxt   = {shreg[DATA_W-2:0], 1'b0};
                        bit_cnt_nxt = bit_cnt + 1'b1;
                        if (bit_cnt == CNT_W'(DATA_W - 1))
                            state_nxt = TRAIL;
                    end
                end
            end
            TRAIL: begin
                if (cs_rise) begin
                    done_nxt  = 1'b1;
                    cnt_nxt   = frame_cnt_o + 8'd1;
                    miso_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else if (sck_fall) begin
                    miso_nxt = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign spi.miso_o = miso;
    assign busy_o     = (state != IDLE);
endmodule

// File: tb/tb_verin_adc_spi_responder.sv
// Directed bench for the ADC SPI responder: frames, data hold, abort, counter wrap,
// mid-frame reset and idle sck activity.
module tb_verin_adc_spi_responder;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [11:0] data;
    logic        busy, frame_done, abort;
    logic [7:0]  frame_cnt;
    int          n_chk = 0;
    int          n_err = 0;
    int          done_cnt = 0;
    int          abort_cnt = 0;
    logic        busy_mid, lat_early, lat_late;
    logic [13:0] bits;

    verin_adc_spi_responder_if spi_if ();

    verin_adc_spi_responder #(.DATA_W(12), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .spi          (spi_if),
        .data_i       (data),
        .busy_o       (busy),
        .frame_done_o (frame_done),
        .abort_o      (abort),
        .frame_cnt_o  (frame_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) done_cnt++;
        if (abort)      abort_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // sck runs at clk/10; miso is sampled just before each sck rise after the first.
    task automatic run_frame(input logic [11:0] d, input logic [11:0] d_after,
                             input int n_sck, output logic [13:0] b);
        data = d;
        spi_if.cs_n_i = 1'b0;
        wait_clk(6);
        data = d_after;
        b = '0;
        for (int i = 0; i < n_sck; i++) begin
            if (i >= 1 && i <= 14) b = {b[12:0], spi_if.miso_o};
            if (i == 1) busy_mid = busy;
            spi_if.sck_i = 1'b1;
            wait_clk(5);
            spi_if.sck_i = 1'b0;
            if (i == 2) begin
                wait_clk(2);
                lat_early = spi_if.miso_o;
                wait_clk(1);
                lat_late = spi_if.miso_o;
                wait_clk(2);
            end else begin
                wait_clk(5);
            end
        end
        wait_clk(5);
        spi_if.cs_n_i = 1'b1;
        wait_clk(8);
    endtask

    initial begin
        reset_n = 1'b0;
        data = '0;
        spi_if.sck_i = 1'b0;
        spi_if.cs_n_i = 1'b1;
        wait_clk(3);
        reset_n = 1'b1;
        wait_clk(4);
        chk("rst_miso", spi_if.miso_o, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", frame_cnt, 0);
        chk("rst_pulses", done_cnt + abort_cnt, 0);

        // 0xA5C -> two leading zeros then 1010_0101_1100
        run_frame(12'hA5C, 12'hA5C, 15, bits);
        chk("a5c_bits", bits, 14'b00_1010_0101_1100);
        chk("a5c_busy_mid", busy_mid, 1);
        chk("a5c_lat_early", lat_early, 0);
        chk("a5c_lat_late", lat_late, 1);
        chk("a5c_done", done_cnt, 1);
        chk("a5c_cnt", frame_cnt, 1);
        chk("a5c_busy_end", busy, 0);
        chk("a5c_miso_end", spi_if.miso_o, 0);

        // data_i cleared after cs_n fall: latched word must still go out
        run_frame(12'hFFF, 12'h000, 15, bits);
        chk("fff_bits", bits, 14'b00_1111_1111_1111);
        chk("fff_cnt", frame_cnt, 2);

        // abort after 6 falls (miso is 1 at that point)
        run_frame(12'hFFF, 12'hFFF, 6, bits);
        chk("abort_pulse", abort_cnt, 1);
        chk("abort_no_done", done_cnt, 2);
        chk("abort_cnt", frame_cnt, 2);
        chk("abort_busy", busy, 0);
        chk("abort_miso", spi_if.miso_o, 0);

        // counter wrap: 2 + 253 = 255, +1 -> 0
        for (int k = 0; k < 253; k++) run_frame(12'h0F0, 12'h0F0, 15, bits);
        chk("cnt_255", frame_cnt, 8'hFF);
        run_frame(12'h0F0, 12'h0F0, 15, bits);
        chk("cnt_wrap", frame_cnt, 8'h00);
        chk("wrap_done", done_cnt, 256);

        // reset pulse during DATA (after 8 falls), cs_n/sck released with reset
        data = 12'hFFF;
        spi_if.cs_n_i = 1'b0;
        wait_clk(6);
        for (int i = 0; i < 8; i++) begin
            spi_if.sck_i = 1'b1;
            wait_clk(5);
            spi_if.sck_i = 1'b0;
            wait_clk(5);
        end
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_miso", spi_if.miso_o, 1);
        reset_n = 1'b0;
        wait_clk(1);
        reset_n = 1'b1;
        spi_if.cs_n_i = 1'b1;
        chk("mid_rst_miso", spi_if.miso_o, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cnt", frame_cnt, 0);
        wait_clk(8);
        chk("mid_rst_no_abort", abort_cnt, 1);
        chk("mid_rst_idle", busy, 0);
        run_frame(12'h123, 12'h123, 15, bits);
        chk("x123_bits", bits, 14'b00_0001_0010_0011);
        chk("x123_cnt", frame_cnt, 1);

        // sck activity with cs_n high must be ignored
        begin
            logic any_miso, any_busy;
            any_miso = 1'b0;
            any_busy = 1'b0;
            for (int i = 0; i < 10; i++) begin
                spi_if.sck_i = 1'b1;
                wait_clk(5);
                any_miso |= spi_if.miso_o;
                any_busy |= busy;
                spi_if.sck_i = 1'b0;
                wait_clk(5);
                any_miso |= spi_if.miso_o;
                any_busy |= busy;
            end
            chk("idle_sck_miso", any_miso, 0);
            chk("idle_sck_busy", any_busy, 0);
            chk("idle_sck_pulses", done_cnt + abort_cnt, 258);
            chk("idle_sck_cnt", frame_cnt, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
